// File: rtl/inst_mem_loadable_if.sv
// ---------------------------------------------------------------------------
// inst_mem_loadable_if
// Bundles the fetch-side and loader-side signals of inst_mem_loadable.
//   master : the CPU/loader side (drives addr, stall, load_en, rx_*)
//   slave  : the memory itself (drives instruction, misaligned, load_*)
// Signals:
//   addr[31:0]        byte address from the IF-stage PC
//   stall             hold the current instruction/misaligned outputs
//   instruction[31:0] registered instruction word
//   misaligned        registered, addr[1:0] != 0 at the sampled read
//   load_en           level request to enter/stay in load mode
//   rx_valid, rx_data one-cycle byte strobe and byte from the UART RX path
//   load_busy         high while loading (CPU holds its PC)
//   load_done         one-cycle pulse when a load ends
//   load_count        words written by the current or last load
// ---------------------------------------------------------------------------
interface inst_mem_loadable_if #(
  parameter int ADDR_W = 8
);
  logic [31:0]     addr;
  logic            stall;
  logic [31:0]     instruction;
  logic            misaligned;
  logic            load_en;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            load_busy;
  logic            load_done;
  logic [ADDR_W:0] load_count;

  modport master (
    output addr, stall, load_en, rx_valid, rx_data,
    input  instruction, misaligned, load_busy, load_done, load_count
  );

  modport slave (
    input  addr, stall, load_en, rx_valid, rx_data,
    output instruction, misaligned, load_busy, load_done, load_count
  );
endinterface

// File: rtl/inst_mem_loadable.sv
// ---------------------------------------------------------------------------
// inst_mem_loadable
// RAM-backed instruction memory for the pipelined MIPS CPU. Reads are
// registered (1-cycle latency) with stall hold; the contents are loaded at
// run time from a byte stream, four bytes packed per word.
// Ports:
//   clk    single clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    inst_mem_loadable_if.slave (see interface header for signals)
// Parameters:
//   ADDR_W word-address width, DEPTH = 2**ADDR_W words
//   FILL   word returned for unwritten/out-of-range words and during a load
//   LITTLE 1: first byte of a word lands in [7:0]; 0: in [31:24]
// ---------------------------------------------------------------------------
module inst_mem_loadable #(
  parameter int          ADDR_W = 8,
  parameter logic [31:0] FILL   = 32'h8000_0000,
  parameter bit          LITTLE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  inst_mem_loadable_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         instruction_q, instruction_d;
  logic                misaligned_q, misaligned_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]   word_ptr_q, word_ptr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic [31:0]         asm_q, asm_d;
  // Set on leaving a load while load_en is still high; blocks re-entry
  // until load_en has been seen low in IDLE.
  logic                rearm_block_q, rearm_block_d;

  logic [31:0]         mem_q [DEPTH];
  logic                mem_we;
  logic [31:0]         asm_next;

  logic [ADDR_W-1:0]   rd_idx;
  logic                out_of_range;

  assign rd_idx       = bus.addr[ADDR_W+1:2];
  assign out_of_range = |bus.addr[31:ADDR_W+2];

  // Word assembler: little-endian shifts bytes in from the top so the first
  // byte ends in [7:0]; big-endian shifts in from the bottom.
  assign asm_next = LITTLE ? {bus.rx_data, asm_q[31:8]}
                           : {asm_q[23:0], bus.rx_data};

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    misaligned_d  = misaligned_q;
    valid_d       = valid_q;
    byte_cnt_d    = byte_cnt_q;
    word_ptr_d    = word_ptr_q;
    load_count_d  = load_count_q;
    asm_d         = asm_q;
    rearm_block_d = rearm_block_q;
    mem_we        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!bus.stall) begin
          instruction_d = (out_of_range || !valid_q[rd_idx]) ? FILL : mem_q[rd_idx];
          misaligned_d  = |bus.addr[1:0];
        end
        if (!bus.load_en) begin
          rearm_block_d = 1'b0;
        end else if (!rearm_block_q) begin
          state_d      = S_LOAD;
          byte_cnt_d   = 2'd0;
          word_ptr_d   = '0;
          load_count_d = '0;
          valid_d      = '0;
        end
      end

      S_LOAD: begin
        instruction_d = FILL;
        if (bus.rx_valid) begin
          asm_d      = asm_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we                = 1'b1;
            valid_d[word_ptr_q]   = 1'b1;
            word_ptr_d            = word_ptr_q + ADDR_W'(1);
            load_count_d          = load_count_q + (ADDR_W+1)'(1);
          end
        end
        // A 4th byte arriving with the load_en fall is still written above;
        // a full memory and a load_en fall give one shared exit.
        if (!bus.load_en || load_count_d == (ADDR_W+1)'(DEPTH)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        instruction_d = FILL;
        rearm_block_d = bus.load_en;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      instruction_q <= FILL;
      misaligned_q  <= 1'b0;
      valid_q       <= '0;
      byte_cnt_q    <= 2'd0;
      word_ptr_q    <= '0;
      load_count_q  <= '0;
      asm_q         <= '0;
      rearm_block_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      misaligned_q  <= misaligned_d;
      valid_q       <= valid_d;
      byte_cnt_q    <= byte_cnt_d;
      word_ptr_q    <= word_ptr_d;
      load_count_q  <= load_count_d;
      asm_q         <= asm_d;
      rearm_block_q <= rearm_block_d;
    end
  end

  // NOTE: the array itself is never reset; the valid vector alone decides
  // whether a word is visible, which keeps the storage mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[word_ptr_q] <= asm_next;
    end
  end

  assign bus.instruction = instruction_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.load_busy   = (state_q == S_LOAD);
  assign bus.load_done   = (state_q == S_DONE);
  assign bus.load_count  = load_count_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loadable
// Scoreboard bench for inst_mem_loadable. dut_a: ADDR_W=8, LITTLE=1.
// dut_b: ADDR_W=2, LITTLE=0 (small enough to fill). The driver issues
// reads/loads on the falling edge and queues expected responses; a monitor
// samples 1 time unit after each rising edge and compares.
// ---------------------------------------------------------------------------
module tb_inst_mem_loadable;

  localparam logic [31:0] FILL = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  inst_mem_loadable_if #(.ADDR_W(8)) ia ();
  inst_mem_loadable_if #(.ADDR_W(2)) ib ();

  inst_mem_loadable #(.ADDR_W(8), .FILL(FILL), .LITTLE(1'b1)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ia)
  );

  inst_mem_loadable #(.ADDR_W(2), .FILL(FILL), .LITTLE(1'b0)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ib)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        mis;
  } rd_exp_t;

  rd_exp_t q_a[$];
  rd_exp_t q_b[$];
  int      done_q_a[$];
  int      done_q_b[$];
  int      checks     = 0;
  int      failures   = 0;
  int      done_cnt_a = 0;
  int      done_cnt_b = 0;
  logic    iss_a      = 1'b0;
  logic    iss_b      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic    pa, pb;
    rd_exp_t e;
    forever begin
      @(posedge clk);
      pa = iss_a;
      pb = iss_b;
      #1;
      if (pa && q_a.size() > 0) begin
        e = q_a.pop_front();
        check({e.name, "_instr"}, ia.instruction, e.instr);
        check({e.name, "_mis"}, 32'(ia.misaligned), 32'(e.mis));
      end
      if (pb && q_b.size() > 0) begin
        e = q_b.pop_front();
        check({e.name, "_instr"}, ib.instruction, e.instr);
        check({e.name, "_mis"}, 32'(ib.misaligned), 32'(e.mis));
      end
      if (ia.load_done) begin
        done_cnt_a++;
        if (done_q_a.size() == 0) check("done_a_unexpected", 32'(ia.load_done), 32'd0);
        else                      check("done_a_count", 32'(ia.load_count), 32'(done_q_a.pop_front()));
      end
      if (ib.load_done) begin
        done_cnt_b++;
        if (done_q_b.size() == 0) check("done_b_unexpected", 32'(ib.load_done), 32'd0);
        else                      check("done_b_count", 32'(ib.load_count), 32'(done_q_b.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rd(input bit b, input logic [31:0] a, input logic st,
                    input logic [31:0] ei, input logic em, input string nm);
    rd_exp_t e;
    @(negedge clk);
    e.name  = nm;
    e.instr = ei;
    e.mis   = em;
    ia.rx_valid = 1'b0;
    ib.rx_valid = 1'b0;
    if (!b) begin
      ia.addr = a; ia.stall = st; iss_a = 1'b1; iss_b = 1'b0;
      q_a.push_back(e);
    end else begin
      ib.addr = a; ib.stall = st; iss_b = 1'b1; iss_a = 1'b0;
      q_b.push_back(e);
    end
  endtask

  task automatic send(input bit b, input logic [7:0] d);
    @(negedge clk);
    iss_a = 1'b0; iss_b = 1'b0;
    if (!b) begin ia.rx_valid = 1'b1; ia.rx_data = d; end
    else    begin ib.rx_valid = 1'b1; ib.rx_data = d; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iss_a = 1'b0; iss_b = 1'b0;
      ia.rx_valid = 1'b0; ib.rx_valid = 1'b0;
    end
  endtask

  task automatic set_load(input bit b, input logic v);
    @(negedge clk);
    iss_a = 1'b0; iss_b = 1'b0;
    ia.rx_valid = 1'b0; ib.rx_valid = 1'b0;
    if (!b) ia.load_en = v;
    else    ib.load_en = v;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] load1 [8] = '{8'h03, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] part  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  initial begin
    ia.addr = '0; ia.stall = 1'b0; ia.load_en = 1'b0; ia.rx_valid = 1'b0; ia.rx_data = '0;
    ib.addr = '0; ib.stall = 1'b0; ib.load_en = 1'b0; ib.rx_valid = 1'b0; ib.rx_data = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_instr_a", ia.instruction, FILL);
    check("rst_mis_a", 32'(ia.misaligned), 32'd0);
    check("rst_busy_a", 32'(ia.load_busy), 32'd0);
    check("rst_done_a", 32'(ia.load_done), 32'd0);
    check("rst_count_a", 32'(ia.load_count), 32'd0);
    check("rst_instr_b", ib.instruction, FILL);
    rst_a = 1'b0;
    rst_b = 1'b0;

    rd(0, 32'h0,   1'b0, FILL, 1'b0, "rst_rd_0");
    rd(0, 32'h4,   1'b0, FILL, 1'b0, "rst_rd_4");
    rd(0, 32'h3FC, 1'b0, FILL, 1'b0, "rst_rd_3fc");

    // Little-endian load of two words
    done_q_a.push_back(2);
    set_load(0, 1'b1);
    foreach (load1[i]) begin
      send(0, load1[i]);
      if (i == 0) check("l1_busy", 32'(ia.load_busy), 32'd1);
    end
    set_load(0, 1'b0);
    idle(1);
    check("l1_done_pulse", 32'(ia.load_done), 32'd1);
    check("l1_busy_in_done", 32'(ia.load_busy), 32'd0);
    rd(0, 32'h0,   1'b0, 32'h0800_0003, 1'b0, "l1_w0");
    rd(0, 32'h4,   1'b0, 32'h0000_0000, 1'b0, "l1_w1");
    rd(0, 32'h8,   1'b0, FILL,          1'b0, "l1_w2");
    rd(0, 32'h400, 1'b0, FILL,          1'b0, "l1_oor");
    check("l1_count", 32'(ia.load_count), 32'd2);
    check("l1_done_once", 32'(done_cnt_a), 32'd1);

    // Misalignment and stall hold
    rd(0, 32'h6, 1'b0, 32'h0000_0000, 1'b1, "mis6");
    rd(0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, "stall1");
    rd(0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, "stall2");
    rd(0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, "stall3");
    rd(0, 32'h0, 1'b0, 32'h0800_0003, 1'b0, "stall_release");

    // Partial word discarded
    done_q_a.push_back(1);
    set_load(0, 1'b1);
    foreach (part[i]) send(0, part[i]);
    set_load(0, 1'b0);
    idle(1);
    rd(0, 32'h0, 1'b0, 32'h4433_2211, 1'b0, "part_w0");
    rd(0, 32'h4, 1'b0, FILL,          1'b0, "part_w1");
    check("part_count", 32'(ia.load_count), 32'd1);
    check("part_done_once", 32'(done_cnt_a), 32'd2);

    // Full memory on dut_b (big-endian), load_en held high throughout
    done_q_b.push_back(4);
    set_load(1, 1'b1);
    for (int i = 1; i <= 20; i++) send(1, 8'(i));
    idle(2);
    check("full_busy", 32'(ib.load_busy), 32'd0);
    check("full_count", 32'(ib.load_count), 32'd4);
    rd(1, 32'h0,  1'b0, 32'h0102_0304, 1'b0, "full_w0");
    rd(1, 32'h4,  1'b0, 32'h0506_0708, 1'b0, "full_w1");
    rd(1, 32'hC,  1'b0, 32'h0D0E_0F10, 1'b0, "full_w3");
    rd(1, 32'h10, 1'b0, FILL,          1'b0, "full_oor");
    idle(1);
    check("full_stay_idle", 32'(ib.load_busy), 32'd0);
    check("full_done_once", 32'(done_cnt_b), 32'd1);
    set_load(1, 1'b0);

    // Reset in the middle of a load
    set_load(0, 1'b1);
    for (int i = 0; i < 5; i++) send(0, 8'hA1 + 8'(i));
    @(negedge clk);
    iss_a = 1'b0;
    ia.rx_valid = 1'b0;
    ia.load_en  = 1'b0;
    rst_a       = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'(ia.load_busy), 32'd0);
    check("rstmid_count", 32'(ia.load_count), 32'd0);
    rst_a = 1'b0;
    idle(2);
    check("rstmid_no_done", 32'(done_cnt_a), 32'd2);
    rd(0, 32'h0, 1'b0, FILL, 1'b0, "rstmid_w0");
    idle(2);

    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_b_drained", 32'(q_b.size()), 32'd0);
    check("done_q_a_drained", 32'(done_q_a.size()), 32'd0);
    check("done_q_b_drained", 32'(done_q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised, synchronous instruction memory for the pipelined MIPS CPU. It replaces the fixed, combinational program ROM with a RAM-backed store that is loaded at run time from a byte stream (the UART RX path). The block sits between the IF-stage PC and the IF/ID register. It provides a registered read with stall hold, misalignment and out-of-range detection, and a load state machine that packs bytes into words.

## Interface
Parameters:
- ADDR_W, 8, word-address width; memory depth DEPTH = 2^ADDR_W words.
- FILL, 32'h80000000, word returned for unwritten words, out-of-range addresses and any read during a load.
- LITTLE, 1, byte order. 1: the first received byte of a word goes to bits [7:0]. 0: it goes to bits [31:24].

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, synchronous, active-high.
- addr, in, 32, byte address (the PC).
- stall, in, 1, hold the current instruction output.
- instruction, out, 32, registered instruction word.
- misaligned, out, 1, registered; 1 when the sampled addr[1:0] != 0.
- load_en, in, 1, level request to enter and stay in load mode.
- rx_valid, in, 1, one-cycle strobe meaning rx_data is valid.
- rx_data, in, 8, received byte.
- load_busy, out, 1, 1 while in LOAD; the CPU holds its PC while this is high.
- load_done, out, 1, one-cycle pulse when a load ends.
- load_count, out, ADDR_W+1, number of words written by the current or last load.

## Operation
- Storage: DEPTH x 32 array plus a DEPTH-bit valid vector. Reset clears the valid vector only; array contents are not reset.
- Read (state IDLE, stall=0): word index = addr[ADDR_W+1:2].
  - If addr[31:ADDR_W+2] != 0 (out of range) or the word's valid bit is 0, instruction <= FILL.
  - Otherwise instruction <= mem[index].
  - misaligned <= |addr[1:0]. Misalignment does not change the word returned.
- stall=1: instruction and misaligned hold their values.
- States:
  - IDLE: normal reads. If load_en=1, go to LOAD. On entry, clear byte_cnt, word_ptr, load_count and the whole valid vector.
  - LOAD: load_busy=1; instruction <= FILL every cycle regardless of stall.
    - Each rx_valid=1 cycle shifts rx_data into the word assembler (order per LITTLE) and increments byte_cnt (2 bits).
    - On the 4th byte, write the assembled word to mem[word_ptr], set valid[word_ptr], then increment word_ptr and load_count.
  - Exits from LOAD to DONE:
    - load_en=0: any partial word (byte_cnt != 0) is discarded and not written.
    - load_count reaches DEPTH: the memory is full, and any further bytes are ignored.
  - DONE: one cycle with load_done=1 and load_busy=0, then IDLE. If load_en is still 1 in DONE, the block still returns to IDLE and does not re-enter LOAD until load_en has been seen at 0.
- Simultaneous events in LOAD:
  - load_en falls in the same cycle as a 4th byte: that word is written, then the exit happens.
  - Full exit and load_en fall together: a single load_done pulse.
- rx_valid outside LOAD is ignored.
- load_count holds its final value until the next LOAD entry.

## Timing
- Read latency is 1 cycle: addr sampled at edge N appears on instruction after edge N.
- Byte-to-write latency: the 4th byte's rx_valid at edge N writes the word at edge N. A read of that word is possible at the earliest in the first IDLE read after DONE.
- Load entry: load_en sampled 1 at edge N gives load_busy=1 after edge N.
- Load exit: the exit condition at edge N gives DONE (load_done=1) for cycle N+1 and IDLE after edge N+1.
- Reset values: instruction=FILL, misaligned=0, load_busy=0, load_done=0, load_count=0, state IDLE, valid vector all 0.
- Reset mid-load: the next cycle is IDLE, the partial word is lost, no load_done pulse occurs, and all words read FILL.
- Throughput: one byte per cycle is accepted; back-to-back rx_valid is legal.

## Test plan
- Reset, then read addr=0x0, 0x4, 0x3FC -> instruction=32'h80000000 each cycle after the address is applied; misaligned=0.
- LITTLE=1: load bytes 0x03,0x00,0x00,0x08 then 0x00,0x00,0x00,0x00, then drop load_en -> load_count=2 and a one-cycle load_done. Reading addr 0x0 gives 32'h08000003, addr 0x4 gives 32'h00000000, addr 0x8 gives FILL.
- Partial word: send 6 bytes, then drop load_en -> load_count=1; word 1 reads FILL.
- Full memory (ADDR_W=2): send 20 bytes with load_en held -> exit after the 16th byte, load_count=4, bytes 17-20 ignored. load_done pulses once, and with load_en still high the block stays in IDLE.
- Stall and misalignment: addr=0x6 -> misaligned=1. Then stall=1 with addr changed to 0x0 -> instruction and misaligned unchanged for 3 cycles; releasing stall updates them on the next edge.
- Reset asserted after 5 bytes of a load -> load_busy=0 the next cycle, no load_done pulse, word 0 reads FILL, load_count=0.
